uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (50 MHz, 9600 bps, 8N1, start/busy handshake) among N_REQ byte sources.
- Round-robin arbitration per byte, or per packet when the lock option is compiled in.
- Sequences the transmitter through the start/busy handshake and returns a per-requester completion pulse.
- Sits between local byte producers (command engine, status reporter, debug tap) and the transceiver's tx_start/tx_data/tx_busy pins.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, line-rate constants and the
// transmit arbiter state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned BAUD        = 9600;
  localparam int unsigned BAUD_DIV    = 5208;
  localparam int unsigned FRAME_BITS  = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker. The winner is the lowest valid index
// strictly above i_ptr, otherwise the lowest valid index at or below it.
// Ports:
//   i_valid  request vector
//   i_ptr    index of the previous winner
//   o_grant  one-hot winner (zero when nothing is valid)
//   o_idx    winner index
//   o_any    any request valid
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  // Wrapped group first, then the group above ptr, each scanned downward so
  // the last hit is the lowest index; the above-ptr group overrides.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (i_valid[i] && (i <= int'(i_ptr))) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = ID_W'(i);
        o_any      = 1'b1;
      end
    end
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (i_valid[i] && (i > int'(i_ptr))) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = ID_W'(i);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources. Each byte is won by
// round-robin, handed to the transceiver with a one-cycle tx_start, and
// completed when tx_busy falls, which raises req_done for that requester.
// A missing tx_busy response within TIMEOUT_CYC cycles drops the byte and
// sets the sticky timeout_err.
// Optional macro UART_TX_ARB_LOCK_EN adds req_last and keeps the grant on one
// requester until a byte flagged last has been sent (or a timeout occurs).
// Ports:
//   clk, rstn               clock, async active-low reset
//   req_valid/req_data      per-requester byte offer (byte i at [8i+7:8i])
//   req_last                (lock build only) marks the final byte of a packet
//   req_ready               combinational acceptance pulse, at most one bit
//   req_done                registered completion pulse
//   tx_start/tx_data        to transceiver
//   tx_busy                 from transceiver
//   grant_id                current/last granted requester
//   arb_active              high outside IDLE
//   timeout_err/err_clr     sticky fault flag and its synchronous clear
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned ID_W        = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]             req_last,
`endif
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             req_done,
  output logic                         tx_start,
  output logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         arb_active,
  output logic                         timeout_err,
  input  logic                         err_clr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  arb_state_e             r_state;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        r_grant_id;
  logic [N_REQ-1:0]       r_req_done;
  logic                   r_tx_start;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_arb_active;
  logic                   r_timeout_err;
  logic [CNT_W-1:0]       r_cnt;

  logic [N_REQ-1:0]       w_valid;
  logic [N_REQ-1:0]       w_grant;
  logic [ID_W-1:0]        w_idx;
  logic                   w_any;
  logic                   w_can_arb;
  logic [UART_DATA_W-1:0] w_bytes [N_REQ];

`ifdef UART_TX_ARB_LOCK_EN
  logic r_lock;
  // While locked only the current owner is visible to the picker.
  assign w_valid = r_lock ? (req_valid & (N_REQ'(1) << r_grant_id)) : req_valid;
`else
  assign w_valid = req_valid;
`endif

  // Split the flat data bus into per-requester bytes.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_valid (w_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Holding off during the req_done cycle guarantees an idle cycle between frames.
  assign w_can_arb = (r_state == ST_IDLE) && !tx_busy && (r_req_done == '0) && w_any;
  assign req_ready = w_can_arb ? w_grant : '0;

  // Sequencer: grant, issue start, wait for busy rise, wait for busy fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_ptr         <= ID_W'(N_REQ - 1);
      r_grant_id    <= '0;
      r_req_done    <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_arb_active  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      r_lock        <= 1'b0;
`endif
    end else begin
      r_req_done <= '0;
      r_tx_start <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (err_clr) r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_can_arb) begin
            r_tx_data    <= w_bytes[w_idx];
            r_grant_id   <= w_idx;
            r_ptr        <= w_idx;
            r_tx_start   <= 1'b1;
            r_arb_active <= 1'b1;
            r_state      <= ST_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
            r_lock       <= !req_last[w_idx];
`endif
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Byte is lost; the requester was already acked, so no req_done.
            r_timeout_err <= 1'b1;
            r_arb_active  <= 1'b0;
            r_state       <= ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            r_lock        <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (!tx_busy) begin
            r_req_done   <= N_REQ'(1) << r_grant_id;
            r_arb_active <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_arb_active <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_done    = r_req_done;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign arb_active  = r_arb_active;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transceiver model that
// raises tx_busy the cycle after tx_start for a programmable number of cycles.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0]  req_last = '0;
`endif
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        arb_active;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = -1;
  int start_cnt = 0;
  int m_len = 20;
  bit m_en = 1'b1;
  int m_cnt = 0;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16), .ID_W(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .req_done    (req_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_active  (arb_active),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transceiver model, independent of the arbiter reset.
  always @(posedge clk) begin
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) tx_busy <= 1'b0;
    end else if (tx_start && m_en) begin
      tx_busy <= 1'b1;
      m_cnt   <= m_len;
    end
  end

  always @(negedge clk) begin
    if (req_done != 4'b0000) done_cyc = cyc;
    if (tx_start) start_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    err_clr = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    req_last = '0;
`endif
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Returns in the cycle where req_ready is seen (no comparison here).
  task automatic wait_ready(input int bound, output int idx, output bit ok);
    ok = 1'b0;
    idx = -1;
    for (int i = 0; i < bound; i++) begin
      #1;
      if (req_ready != 4'b0000) begin
        ok = 1'b1;
        for (int j = 0; j < 4; j++) if (req_ready[j]) idx = j;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (req_done != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++;
    if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++;
    if ({req_done, tx_start, arb_active, timeout_err, req_ready} !== 11'b0) begin
      failures++;
      $display("FAIL reset_flags: done=%b start=%b active=%b err=%b ready=%b expected all 0",
               req_done, tx_start, arb_active, timeout_err, req_ready);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    int idx; bit ok; int t;
    m_len = 52080;
    m_en = 1'b1;
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    wait_ready(10, idx, ok);
    t = cyc;
    checks++;
    if (!ok || req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      failures++; $display("FAIL single_start: start=%b data=%h expected 1 a5", tx_start, tx_data);
    end
    checks++;
    if (grant_id !== 2'd0 || arb_active !== 1'b1) begin
      failures++; $display("FAIL single_grant: id=%0d active=%b expected 0 1", grant_id, arb_active);
    end
    tick();
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_width: got %b expected 0", tx_start); end
    wait_done(60000, ok);
    checks++;
    if (!ok || cyc != t + 52083 || req_done !== 4'b0001) begin
      failures++; $display("FAIL single_done: at cycle %0d value %b expected cycle %0d value 0001", cyc, req_done, t + 52083);
    end
    tick();
    checks++;
    if (req_done !== 4'b0000 || arb_active !== 1'b0) begin
      failures++; $display("FAIL single_after: done=%b active=%b expected 0000 0", req_done, arb_active);
    end
  endtask

  task automatic test_round_robin();
    int idx; bit ok; int s0; int exp;
    do_reset();
    m_len = 20;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    s0 = start_cnt;
    for (int f = 0; f < 5; f++) begin
      exp = f % 4;
      wait_ready(200, idx, ok);
      checks++;
      if (!ok || req_ready !== (4'b0001 << exp)) begin
        failures++; $display("FAIL rr_order frame %0d: got %b expected %b", f, req_ready, 4'b0001 << exp);
      end
      if (f > 0) begin
        checks++;
        if (cyc != done_cyc + 1) begin
          failures++; $display("FAIL rr_gap frame %0d: ready at %0d expected %0d", f, cyc, done_cyc + 1);
        end
      end
      tick();
      checks++;
      if (tx_start !== 1'b1 || tx_data !== 8'(16 + exp) || grant_id !== 2'(exp)) begin
        failures++; $display("FAIL rr_issue frame %0d: start=%b data=%h id=%0d expected 1 %h %0d",
                             f, tx_start, tx_data, grant_id, 8'(16 + exp), exp);
      end
    end
    req_valid = 4'b0000;
    wait_done(100, ok);
    tick();
    checks++;
    if (!ok || start_cnt - s0 != 5) begin
      failures++; $display("FAIL rr_start_count: got %0d expected 5", start_cnt - s0);
    end
  endtask

  task automatic test_ptr_wrap();
    int idx; bit ok;
    do_reset();
    req_valid = 4'b0010;
    wait_ready(20, idx, ok);
    checks++;
    if (!ok || idx != 1) begin failures++; $display("FAIL wrap_first: got %0d expected 1", idx); end
    tick();
    req_valid = 4'b0000;
    wait_done(100, ok);
    req_valid = 4'b1010;
    wait_ready(20, idx, ok);
    checks++;
    if (!ok || idx != 3) begin failures++; $display("FAIL wrap_above_ptr: got %0d expected 3", idx); end
    tick();
    req_valid = 4'b0010;
    wait_ready(200, idx, ok);
    checks++;
    if (!ok || idx != 1) begin failures++; $display("FAIL wrap_around: got %0d expected 1", idx); end
    tick();
    req_valid = 4'b0000;
    wait_done(100, ok);
  endtask

  task automatic test_timeout();
    int idx; bit ok; int t;
    do_reset();
    m_en = 1'b0;
    req_valid = 4'b0001;
    wait_ready(20, idx, ok);
    t = cyc;
    tick();
    req_valid = 4'b0000;
    while (cyc < t + 17) tick();
    checks++;
    if (timeout_err !== 1'b0 || arb_active !== 1'b1) begin
      failures++; $display("FAIL timeout_early: err=%b active=%b expected 0 1", timeout_err, arb_active);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || arb_active !== 1'b0) begin
      failures++; $display("FAIL timeout_set: err=%b active=%b expected 1 0", timeout_err, arb_active);
    end
    checks++;
    if (done_cyc >= t) begin failures++; $display("FAIL timeout_no_done: done at %0d expected none after %0d", done_cyc, t); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
    // Second timeout with err_clr held on the setting edge.
    req_valid = 4'b0010;
    wait_ready(20, idx, ok);
    t = cyc;
    checks++;
    if (!ok || idx != 1) begin failures++; $display("FAIL timeout_next_grant: got %0d expected 1", idx); end
    tick();
    req_valid = 4'b0000;
    while (cyc < t + 17) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_set_wins: got %b expected 1", timeout_err); end
    m_en = 1'b1;
    req_valid = 4'b0100;
    wait_ready(20, idx, ok);
    checks++;
    if (!ok || idx != 2) begin failures++; $display("FAIL timeout_recover_grant: got %0d expected 2", idx); end
    tick();
    req_valid = 4'b0000;
    wait_done(100, ok);
    checks++;
    if (!ok || req_done !== 4'b0100 || timeout_err !== 1'b1) begin
      failures++; $display("FAIL timeout_recover_done: done=%b err=%b expected 0100 1", req_done, timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int idx; bit ok; int d0;
    do_reset();
    m_len = 40;
    req_valid = 4'b0100;
    wait_ready(20, idx, ok);
    tick();
    req_valid = 4'b0000;
    repeat (5) tick();
    checks++;
    if (arb_active !== 1'b1 || tx_busy !== 1'b1) begin
      failures++; $display("FAIL midrst_setup: active=%b busy=%b expected 1 1", arb_active, tx_busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({req_done, tx_start, arb_active, timeout_err} !== 7'b0 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
      failures++; $display("FAIL midrst_values: done=%b start=%b active=%b err=%b data=%h id=%0d expected all 0",
                           req_done, tx_start, arb_active, timeout_err, tx_data, grant_id);
    end
    tick();
    tick();
    rstn = 1'b1;
    d0 = done_cyc;
    req_valid = 4'b0101;
    wait_ready(200, idx, ok);
    checks++;
    if (!ok || idx != 0) begin failures++; $display("FAIL midrst_restart: got %0d expected 0", idx); end
    checks++;
    if (done_cyc != d0) begin failures++; $display("FAIL midrst_no_done: done at %0d expected none", done_cyc); end
    tick();
    req_valid = 4'b0000;
    wait_done(100, ok);
  endtask

`ifdef UART_TX_ARB_LOCK_EN
  task automatic test_lock();
    int idx; bit ok;
    do_reset();
    m_len = 20;
    req_last = 4'b0000;
    req_valid = 4'b0100;
    wait_ready(20, idx, ok);
    checks++;
    if (!ok || idx != 2) begin failures++; $display("FAIL lock_byte1: got %0d expected 2", idx); end
    tick();
    req_valid = 4'b0101;
    wait_ready(200, idx, ok);
    checks++;
    if (!ok || idx != 2) begin failures++; $display("FAIL lock_byte2: got %0d expected 2", idx); end
    tick();
    req_last = 4'b0100;
    wait_ready(200, idx, ok);
    checks++;
    if (!ok || idx != 2) begin failures++; $display("FAIL lock_byte3: got %0d expected 2", idx); end
    tick();
    req_last = 4'b0000;
    req_valid = 4'b0001;
    wait_ready(200, idx, ok);
    checks++;
    if (!ok || idx != 0) begin failures++; $display("FAIL lock_release: got %0d expected 0", idx); end
    tick();
    req_valid = 4'b0000;
    wait_done(100, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_ptr_wrap();
    test_timeout();
    test_reset_mid_frame();
`ifdef UART_TX_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
